sd_loader_pio_ctrl: RTL and testbench

Parametrised Avalon-MM parallel I/O slave for the SD-loader Nios subsystem, the successor to the single-bit command/acknowledge output ports. It drives an OUT_WIDTH-bit output port with atomic set/clear and self-timed pulse writes. It also samples an IN_WIDTH-bit input port through synchronisers, captures edges and raises a maskable interrupt to the CPU.

---
 rtl/sd_loader_pio_pkg.sv | 22 ++
 rtl/pio_sync_edge.sv | 45 ++++
 rtl/sd_loader_pio_ctrl.sv | 141 ++++++++++++++
 tb/tb_sd_loader_pio_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_loader_pio_pkg.sv
// Shared constants for the SD-loader PIO slave: register map, edge modes and
// the pulse counter sizing helper.
package sd_loader_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_PULSE    = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Counter must be able to hold PULSE_LEN itself.
    function automatic int cnt_width(input int pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop synchroniser per input bit followed by a history flop; produces the
// synchronised value and a one-cycle edge strobe of the selected polarity.
module pio_sync_edge
    import sd_loader_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_stb
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        case (EDGE_TYPE)
            EDGE_FALL: edge_stb = ~sync2_q & prev_q;
            EDGE_ANY:  edge_stb = sync2_q ^ prev_q;
            default:   edge_stb = sync2_q & ~prev_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_out = sync2_q;

endmodule

// File: rtl/sd_loader_pio_ctrl.sv
// Avalon-MM PIO slave: output register with set/clear/self-timed pulse writes,
// synchronised inputs with edge capture and a maskable level interrupt.
module sd_loader_pio_ctrl
    import sd_loader_pio_pkg::*;
#(
    parameter int                   OUT_WIDTH = 8,
    parameter int                   IN_WIDTH  = 8,
    parameter int                   EDGE_TYPE = EDGE_RISE,
    parameter int                   PULSE_LEN = 16,
    parameter logic [OUT_WIDTH-1:0] RESET_OUT = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);

    localparam int               CNT_W    = cnt_width(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [OUT_WIDTH-1:0] pmask_q, pmask_d;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic [IN_WIDTH-1:0]  cap_q, cap_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 expire_q, expire_d;

    logic [IN_WIDTH-1:0]  sync_val;
    logic [IN_WIDTH-1:0]  edge_stb;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;
    logic                 we;
    logic                 pulse_we;
    logic                 expire;
    logic                 unused_wdata;

    pio_sync_edge #(
        .WIDTH    (IN_WIDTH),
        .EDGE_TYPE(EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(in_port),
        .sync_out(sync_val),
        .edge_stb(edge_stb)
    );

    assign we           = chipselect & ~write_n;
    assign pulse_we     = we && (address == ADDR_PULSE);
    assign wd_out       = writedata[OUT_WIDTH-1:0];
    assign wd_in        = writedata[IN_WIDTH-1:0];
    assign unused_wdata = ^writedata;
    // Expiry is registered one cycle behind the 1->0 count so a pulse spans PULSE_LEN+1 cycles;
    // a retrigger landing on that cycle cancels the pending expiry.
    assign expire       = expire_q & ~pulse_we;

    always_comb begin
        out_d    = out_q;
        pmask_d  = pmask_q;
        mask_d   = mask_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;

        if (expire) begin
            out_d   = out_q & ~pmask_q;
            pmask_d = '0;
        end

        if (pulse_we) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CNT_ONE;
            expire_d = (cnt_q == CNT_ONE);
        end

        // CPU writes are applied after expiry so they win on the same bits.
        if (we) begin
            case (address)
                ADDR_OUT: begin
                    out_d   = wd_out;
                    pmask_d = pmask_d & wd_out;
                end
                ADDR_IRQ_MASK: mask_d = wd_in;
                ADDR_EDGE_CAP: cap_d = cap_q & ~wd_in;
                ADDR_OUTSET:   out_d = out_d | wd_out;
                ADDR_OUTCLEAR: begin
                    out_d   = out_d & ~wd_out;
                    pmask_d = pmask_d & ~wd_out;
                end
                ADDR_PULSE: begin
                    out_d   = out_d | wd_out;
                    pmask_d = pmask_q | wd_out;
                end
                default: ;
            endcase
        end

        cap_d = cap_d | edge_stb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_OUT;
            pmask_q  <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            pmask_q  <= pmask_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(sync_val);
            ADDR_OUT:      readdata = 32'(out_q);
            ADDR_IRQ_MASK: readdata = 32'(mask_q);
            ADDR_EDGE_CAP: readdata = 32'(cap_q);
            default:       readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_sd_loader_pio_ctrl.sv
// Directed bench for sd_loader_pio_ctrl: one instance in rising-edge mode and
// one in any-edge mode share the bus and input pins.
module tb_sd_loader_pio_ctrl;
    import sd_loader_pio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_rise, rd_any;
    logic [7:0]  out_rise, out_any;
    logic        irq_rise, irq_any;

    int vectors;
    int miscompares;
    logic [31:0] exp32;
    logic [7:0]  exp8;

    sd_loader_pio_ctrl #(
        .OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(0), .PULSE_LEN(16), .RESET_OUT(8'h81)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .out_port(out_rise), .irq(irq_rise)
    );

    sd_loader_pio_ctrl #(
        .OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(2), .PULSE_LEN(16), .RESET_OUT(8'h81)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .out_port(out_any), .irq(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_port = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out_rise !== 8'h81) begin miscompares++; $display("[TB] FAIL reset_out: got %h expected %h", out_rise, 8'h81); end
        vectors++; if (irq_rise !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq: got %b expected 0", irq_rise); end
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_rise !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cap_rd: got %h expected 0", rd_rise); end
        bus_read(ADDR_IRQ_MASK);
        vectors++; if (rd_rise !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mask_rd: got %h expected 0", rd_rise); end
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a));
            exp32 = (a == 1) ? 32'h81 : 32'h0;
            vectors++; if (rd_rise !== exp32) begin miscompares++; $display("[TB] FAIL reset_read_addr%0d: got %h expected %h", a, rd_rise, exp32); end
        end
    endtask

    task automatic test_out_setclr;
        bus_write(ADDR_OUT, 32'h0000_00A5);
        vectors++; if (out_rise !== 8'hA5) begin miscompares++; $display("[TB] FAIL out_write: got %h expected %h", out_rise, 8'hA5); end
        bus_write(ADDR_OUTSET, 32'hFFFF_FF0F);
        vectors++; if (out_rise !== 8'hAF) begin miscompares++; $display("[TB] FAIL outset: got %h expected %h", out_rise, 8'hAF); end
        bus_write(ADDR_OUTCLEAR, 32'h0000_0081);
        vectors++; if (out_rise !== 8'h2E) begin miscompares++; $display("[TB] FAIL outclear: got %h expected %h", out_rise, 8'h2E); end
        bus_read(ADDR_OUT);
        vectors++; if (rd_rise !== 32'h2E) begin miscompares++; $display("[TB] FAIL out_readback: got %h expected %h", rd_rise, 32'h2E); end
    endtask

    task automatic test_pulse;
        bus_write(ADDR_PULSE, 32'h04);
        vectors++; if (out_rise !== 8'h2E) begin miscompares++; $display("[TB] FAIL pulse_start: got %h expected %h", out_rise, 8'h2E); end
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            exp8 = (k <= 16) ? 8'h2E : 8'h2A;
            vectors++; if (out_rise !== exp8) begin miscompares++; $display("[TB] FAIL pulse_cycle%0d: got %h expected %h", k, out_rise, exp8); end
        end
    endtask

    task automatic test_retrigger;
        bus_write(ADDR_PULSE, 32'h04);
        repeat (9) @(posedge clk);
        #1;
        vectors++; if (out_rise !== 8'h2E) begin miscompares++; $display("[TB] FAIL retrig_pre: got %h expected %h", out_rise, 8'h2E); end
        bus_write(ADDR_PULSE, 32'h04);
        for (int j = 1; j <= 17; j++) begin
            @(posedge clk); #1;
            exp8 = (j <= 16) ? 8'h2E : 8'h2A;
            vectors++; if (out_rise !== exp8) begin miscompares++; $display("[TB] FAIL retrig_cycle%0d: got %h expected %h", j + 10, out_rise, exp8); end
        end
    endtask

    task automatic test_expiry_collision;
        bus_write(ADDR_PULSE, 32'h01);
        vectors++; if (out_rise !== 8'h2B) begin miscompares++; $display("[TB] FAIL coll_pulse: got %h expected %h", out_rise, 8'h2B); end
        repeat (16) @(posedge clk);
        #1;
        bus_write(ADDR_OUTSET, 32'h01);
        vectors++; if (out_rise !== 8'h2B) begin miscompares++; $display("[TB] FAIL coll_set_wins: got %h expected %h", out_rise, 8'h2B); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out_rise !== 8'h2B) begin miscompares++; $display("[TB] FAIL coll_hold: got %h expected %h", out_rise, 8'h2B); end
        bus_write(ADDR_OUTCLEAR, 32'h01);
        vectors++; if (out_rise !== 8'h2A) begin miscompares++; $display("[TB] FAIL coll_clear: got %h expected %h", out_rise, 8'h2A); end
    endtask

    task automatic test_edge_rise;
        bus_write(ADDR_IRQ_MASK, 32'h01);
        bus_read(ADDR_IRQ_MASK);
        vectors++; if (rd_rise !== 32'h01) begin miscompares++; $display("[TB] FAIL mask_readback: got %h expected %h", rd_rise, 32'h01); end
        @(negedge clk) in_port[0] = 1'b1;
        @(posedge clk); #1;
        vectors++; if (irq_rise !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_irq_n1: got %b expected 0", irq_rise); end
        @(posedge clk); #1;
        vectors++; if (irq_rise !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_irq_n2: got %b expected 0", irq_rise); end
        bus_read(ADDR_DATA);
        vectors++; if (rd_rise !== 32'h01) begin miscompares++; $display("[TB] FAIL data_sync: got %h expected %h", rd_rise, 32'h01); end
        @(posedge clk); #1;
        vectors++; if (irq_rise !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_irq_n3: got %b expected 1", irq_rise); end
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_rise !== 32'h01) begin miscompares++; $display("[TB] FAIL edge_cap: got %h expected %h", rd_rise, 32'h01); end

        bus_write(ADDR_EDGE_CAP, 32'h01);
        vectors++; if (irq_rise !== 1'b0) begin miscompares++; $display("[TB] FAIL w1c_irq: got %b expected 0", irq_rise); end
        @(negedge clk) in_port[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (irq_rise !== 1'b0) begin miscompares++; $display("[TB] FAIL fall_ignored: got %b expected 0", irq_rise); end
        @(negedge clk) in_port[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus_write(ADDR_EDGE_CAP, 32'h01);
        vectors++; if (irq_rise !== 1'b1) begin miscompares++; $display("[TB] FAIL set_wins_irq: got %b expected 1", irq_rise); end
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_rise !== 32'h01) begin miscompares++; $display("[TB] FAIL set_wins_cap: got %h expected %h", rd_rise, 32'h01); end
        bus_write(ADDR_EDGE_CAP, 32'h01);
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_rise !== 32'h00) begin miscompares++; $display("[TB] FAIL w1c_cap: got %h expected 0", rd_rise); end
    endtask

    task automatic test_edge_any;
        bus_write(ADDR_EDGE_CAP, 32'hFF);
        bus_write(ADDR_IRQ_MASK, 32'h00);
        @(negedge clk) in_port[3] = 1'b1;
        repeat (4) @(posedge clk);
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_any !== 32'h08) begin miscompares++; $display("[TB] FAIL any_rise_cap: got %h expected %h", rd_any, 32'h08); end
        bus_write(ADDR_EDGE_CAP, 32'h08);
        @(negedge clk) in_port[3] = 1'b0;
        repeat (4) @(posedge clk);
        bus_read(ADDR_EDGE_CAP);
        vectors++; if (rd_any !== 32'h08) begin miscompares++; $display("[TB] FAIL any_fall_cap: got %h expected %h", rd_any, 32'h08); end
        vectors++; if (rd_rise !== 32'h00) begin miscompares++; $display("[TB] FAIL rise_mode_fall: got %h expected 0", rd_rise); end
        vectors++; if (irq_any !== 1'b0) begin miscompares++; $display("[TB] FAIL any_irq_masked: got %b expected 0", irq_any); end
        bus_write(ADDR_IRQ_MASK, 32'h08);
        vectors++; if (irq_any !== 1'b1) begin miscompares++; $display("[TB] FAIL any_irq_unmask: got %b expected 1", irq_any); end
    endtask

    task automatic test_reset_mid_pulse;
        bus_write(ADDR_PULSE, 32'h04);
        vectors++; if (out_rise !== 8'h2E) begin miscompares++; $display("[TB] FAIL rstp_start: got %h expected %h", out_rise, 8'h2E); end
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        vectors++; if (out_rise !== 8'h81) begin miscompares++; $display("[TB] FAIL rstp_async: got %h expected %h", out_rise, 8'h81); end
        vectors++; if (irq_any !== 1'b0) begin miscompares++; $display("[TB] FAIL rstp_irq: got %b expected 0", irq_any); end
        @(negedge clk) reset_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        vectors++; if (out_rise !== 8'h81) begin miscompares++; $display("[TB] FAIL rstp_idle: got %h expected %h", out_rise, 8'h81); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        address = '0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        in_port = '0;
        test_reset();
        test_out_setclr();
        test_pulse();
        test_retrigger();
        test_expiry_collision();
        test_edge_rise();
        test_edge_any();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
